// File: rtl/vga_frame_capture_if.sv
// rtl/vga_frame_capture_if.sv - VGA sample inputs plus capture-port and frame-status outputs
interface vga_frame_capture_if #(
    parameter int CAP_ADDR_WIDTH = 19
);
    logic                      pixel_en_i;
    logic                      hsync_i;
    logic                      vsync_i;
    logic                      vga_red_i;
    logic                      vga_green_i;
    logic                      vga_blue_i;
    logic                      wr_en_o;
    logic [CAP_ADDR_WIDTH-1:0] wr_addr_o;
    logic [2:0]                wr_data_o;
    logic                      locked_o;
    logic                      sync_error_o;
    logic                      frame_done_o;
    logic [15:0]               frame_count_o;
    logic [15:0]               frame_crc_o;

    modport master (
        output pixel_en_i, hsync_i, vsync_i, vga_red_i, vga_green_i, vga_blue_i,
        input  wr_en_o, wr_addr_o, wr_data_o, locked_o, sync_error_o,
        input  frame_done_o, frame_count_o, frame_crc_o
    );

    modport slave (
        input  pixel_en_i, hsync_i, vsync_i, vga_red_i, vga_green_i, vga_blue_i,
        output wr_en_o, wr_addr_o, wr_data_o, locked_o, sync_error_o,
        output frame_done_o, frame_count_o, frame_crc_o
    );
endinterface

// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA receive decoder: sync lock, pixel capture writes, frame stats
// Define CAPTURE_CRC_EN to add a per-frame CRC-16-CCITT of captured pixels on frame_crc_o.
module vga_frame_capture #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int H_SYNC         = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int H_TOTAL        = 800,
    parameter int V_SYNC         = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter int V_TOTAL        = 525,
    parameter int CAP_ADDR_WIDTH = 19
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    vga_frame_capture_if.slave bus
);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int H_START = H_SYNC + H_BACK_PORCH;
    localparam int V_START = V_SYNC + V_BACK_PORCH;

    typedef enum logic [1:0] {SEEK, ALIGN, LOCKED} state_t;

    state_t                    state, state_next;
    logic                      have_ref, have_ref_next;
    logic                      hs_q, vs_q, hs_prev, vs_prev, tick_d;
    logic [2:0]                rgb_q;
    logic [HW-1:0]             hcount, hcount_next;
    logic [VW-1:0]             vcount, vcount_next;
    logic                      hs_fall, vs_fall, line_ok, frame_ok;
    logic                      err_set, done, lock_enter, write;
    logic                      h_active, v_active;
    logic [CAP_ADDR_WIDTH-1:0] addr_next;
    logic                      wr_en;
    logic [CAP_ADDR_WIDTH-1:0] wr_addr;
    logic [2:0]                wr_data;
    logic                      sync_error, frame_done;
    logic [15:0]               frame_count;

    // Stage 1: sample on the pixel tick; stage 2 (tick_d) decodes edges and counts
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
            rgb_q   <= 3'b000;
            tick_d  <= 1'b0;
        end else begin
            tick_d <= bus.pixel_en_i;
            if (bus.pixel_en_i) begin
                hs_prev <= hs_q;
                vs_prev <= vs_q;
                hs_q    <= bus.hsync_i;
                vs_q    <= bus.vsync_i;
                rgb_q   <= {bus.vga_red_i, bus.vga_green_i, bus.vga_blue_i};
            end
        end
    end

    assign hs_fall  = tick_d && hs_prev && !hs_q;
    assign vs_fall  = tick_d && vs_prev && !vs_q;
    assign line_ok  = (hcount == HW'(H_TOTAL - 1));
    assign frame_ok = (vcount == VW'(V_TOTAL - 1));

    always_comb begin
        hcount_next = hcount;
        vcount_next = vcount;
        if (tick_d) begin
            if (hs_fall)
                hcount_next = '0;
            else if (hcount != HW'(H_TOTAL))
                hcount_next = hcount + HW'(1);
            if (vs_fall)
                vcount_next = '0;
            else if (hs_fall && vcount != VW'(V_TOTAL))
                vcount_next = vcount + VW'(1);
        end
    end

    // have_ref marks that ALIGN has a trustworthy vsync edge to measure the frame from
    always_comb begin
        state_next    = state;
        have_ref_next = have_ref;
        err_set       = 1'b0;
        done          = 1'b0;
        case (state)
            SEEK: begin
                if (vs_fall) begin
                    state_next    = ALIGN;
                    have_ref_next = 1'b1;
                end
            end
            ALIGN: begin
                if (vs_fall) begin
                    if (have_ref && frame_ok) begin
                        state_next = LOCKED;
                    end else begin
                        err_set       = have_ref;
                        have_ref_next = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (vs_fall && !frame_ok) begin
                    err_set       = 1'b1;
                    state_next    = ALIGN;
                    have_ref_next = 1'b1;
                end else if (hs_fall && !line_ok) begin
                    err_set       = 1'b1;
                    state_next    = ALIGN;
                    have_ref_next = vs_fall;
                end else if (vs_fall) begin
                    done = 1'b1;
                end
            end
            default: begin
                state_next    = SEEK;
                have_ref_next = 1'b0;
            end
        endcase
    end

    assign lock_enter = (state != LOCKED) && (state_next == LOCKED);

    always_comb begin
        h_active  = (hcount_next >= HW'(H_START)) && (hcount_next < HW'(H_START + ACTIVE_COLUMNS));
        v_active  = (vcount_next >= VW'(V_START)) && (vcount_next < VW'(V_START + ACTIVE_ROWS));
        write     = tick_d && (state == LOCKED) && (state_next == LOCKED) && h_active && v_active;
        addr_next = CAP_ADDR_WIDTH'(vcount_next - VW'(V_START)) * CAP_ADDR_WIDTH'(ACTIVE_COLUMNS)
                  + CAP_ADDR_WIDTH'(hcount_next - HW'(H_START));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= SEEK;
            have_ref    <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 3'b000;
            sync_error  <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            state      <= state_next;
            have_ref   <= have_ref_next;
            hcount     <= hcount_next;
            vcount     <= vcount_next;
            wr_en      <= write;
            frame_done <= done;
            if (write) begin
                wr_addr <= addr_next;
                wr_data <= rgb_q;
            end
            if (err_set)
                sync_error <= 1'b1;
            if (done)
                frame_count <= frame_count + 16'd1;
        end
    end

`ifdef CAPTURE_CRC_EN
    logic [15:0] crc_run, crc_last;

    function automatic logic [15:0] crc_step3(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 2; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    // Restart on lock entry too, so pixels of an aborted frame never leak into the next result
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            crc_run  <= 16'hFFFF;
            crc_last <= 16'h0000;
        end else if (done) begin
            crc_last <= crc_run;
            crc_run  <= 16'hFFFF;
        end else if (lock_enter) begin
            crc_run <= 16'hFFFF;
        end else if (write) begin
            crc_run <= crc_step3(crc_run, rgb_q);
        end
    end

    assign bus.frame_crc_o = crc_last;
`else
    logic unused_lock_enter;
    assign unused_lock_enter = lock_enter;
    assign bus.frame_crc_o   = 16'h0000;
`endif

    assign bus.wr_en_o       = wr_en;
    assign bus.wr_addr_o     = wr_addr;
    assign bus.wr_data_o     = wr_data;
    assign bus.locked_o      = (state == LOCKED);
    assign bus.sync_error_o  = sync_error;
    assign bus.frame_done_o  = frame_done;
    assign bus.frame_count_o = frame_count;
endmodule
